// File: rtl/s27_obs_pkg.sv
// Shared types and helpers for the s27 state observer.
// The candidate set is a one-hot-per-state mask indexed by {g5,g6,g7}.
package s27_obs_pkg;

    typedef logic [2:0] state_t;
    typedef logic [7:0] mask_t;

    localparam mask_t MASK_ALL = 8'hFF;

    function automatic logic mask_is_onehot(input mask_t m);
        return (m != '0) && ((m & (m - mask_t'(1))) == '0);
    endfunction

    // Index of the highest set bit; only meaningful for a one-hot mask.
    function automatic state_t mask_index(input mask_t m);
        state_t idx;
        idx = '0;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) idx = state_t'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/s27_step.sv
// Combinational model of one s27 cycle: output g17 and next {g5,g6,g7}
// for a given present state and primary inputs {g3,g2,g1,g0}.
module s27_step
    import s27_obs_pkg::*;
(
    input  state_t     st_i,
    input  logic [3:0] g_in_i,
    output logic       g17p_o,
    output state_t     nxt_o
);

    logic g0, g1, g2, g3;
    logic g5, g6, g7;
    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;

    assign {g3, g2, g1, g0} = g_in_i;
    assign {g5, g6, g7}     = st_i;

    assign g14 = ~g0;
    assign g12 = ~(g1 | g7);
    assign g8  = g6 & g14;
    assign g13 = ~(g2 | g12);
    assign g15 = g8 | g12;
    assign g16 = g3 | g8;
    assign g9  = ~(g15 & g16);
    assign g11 = ~(g5 | g9);
    assign g10 = ~(g11 | g14);

    assign g17p_o = ~g11;
    assign nxt_o  = {g10, g11, g13};

endmodule

// File: rtl/s27_observer.sv
// Tracks the set of s27 states consistent with observed (g_in, g17) pairs.
// Define S27_OBS_STEPCNT_EN to add the 'steps' observation counter output.
module s27_observer
    import s27_obs_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic             valid,
    input  logic [3:0]       g_in,
    input  logic             g17,
    input  logic             arm,
    output logic [7:0]       mask,
    output logic             locked,
    output logic [2:0]       state,
`ifdef S27_OBS_STEPCNT_EN
    output logic [CNT_W-1:0] steps,
`endif
    output logic             conflict
);

    logic   [7:0] g17p;
    state_t       nxt [8];

    mask_t mask_q, mask_d;
    logic  conflict_q, conflict_d;
    mask_t succ;
    logic  dead;

    for (genvar k = 0; k < 8; k++) begin : g_cand
        s27_step u_step (
            .st_i   (state_t'(k)),
            .g_in_i (g_in),
            .g17p_o (g17p[k]),
            .nxt_o  (nxt[k])
        );
    end

    // Survivors are candidates whose predicted output matches; each maps to its successor.
    always_comb begin
        succ = '0;
        for (int k = 0; k < 8; k++) begin
            if (mask_q[k] && (g17p[k] == g17)) begin
                succ[nxt[k]] = 1'b1;
            end
        end
        dead = (succ == '0);
    end

    always_comb begin
        mask_d     = mask_q;
        conflict_d = conflict_q;
        if (arm) begin
            mask_d     = MASK_ALL;
            conflict_d = 1'b0;
        end else if (valid) begin
            if (dead) begin
                mask_d     = MASK_ALL;
                conflict_d = 1'b1;
            end else begin
                mask_d = succ;
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            mask_q     <= MASK_ALL;
            conflict_q <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            conflict_q <= conflict_d;
        end
    end

    assign mask     = mask_q;
    assign conflict = conflict_q;
    assign locked   = mask_is_onehot(mask_q);
    assign state    = locked ? mask_index(mask_q) : 3'd0;

`ifdef S27_OBS_STEPCNT_EN
    logic [CNT_W-1:0] steps_q, steps_d;

    // Counting stops once identified and sticks at full scale.
    always_comb begin
        steps_d = steps_q;
        if (arm) begin
            steps_d = '0;
        end else if (valid) begin
            if (dead) begin
                steps_d = '0;
            end else if (!locked && (steps_q != '1)) begin
                steps_d = steps_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            steps_q <= '0;
        end else begin
            steps_q <= steps_d;
        end
    end

    assign steps = steps_q;
`endif

endmodule

// File: tb/tb_s27_observer.sv
// Directed-vector bench for s27_observer plus a reference-model tracking run.
module tb_s27_observer;

    localparam int CNT_W = 8;

    logic             clk;
    logic             r;
    logic             valid;
    logic [3:0]       g_in;
    logic             g17;
    logic             arm;
    logic [7:0]       mask;
    logic             locked;
    logic [2:0]       state;
    logic             conflict;
`ifdef S27_OBS_STEPCNT_EN
    logic [CNT_W-1:0] steps;
`endif

    int total = 0;
    int bad   = 0;

    s27_observer #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .r        (r),
        .valid    (valid),
        .g_in     (g_in),
        .g17      (g17),
        .arm      (arm),
        .mask     (mask),
        .locked   (locked),
        .state    (state),
`ifdef S27_OBS_STEPCNT_EN
        .steps    (steps),
`endif
        .conflict (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       arm;
        logic       valid;
        logic [3:0] g;
        logic       g17;
        logic [7:0] mask;
        logic       lk;
        logic [2:0] st;
        logic       cf;
        int         steps;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference s27: returns {g17, next {g5,g6,g7}}.
    function automatic logic [3:0] ref_step(input logic [2:0] s, input logic [3:0] g);
        logic a0, a1, a2, a3, f5, f6, f7;
        logic n8, n9, n10, n11, n12, n13, n14, n15, n16;
        {a3, a2, a1, a0} = g;
        {f5, f6, f7} = s;
        n14 = ~a0;
        n12 = ~(a1 | f7);
        n8  = f6 & n14;
        n13 = ~(a2 | n12);
        n15 = n8 | n12;
        n16 = a3 | n8;
        n9  = ~(n15 & n16);
        n11 = ~(f5 | n9);
        n10 = ~(n11 | n14);
        return {~n11, n10, n11, n13};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ms;
        logic [3:0] rv;
        logic       seen_lock;

        //             arm   vld   g_in     g17   mask   lk    st    cf   steps
        tbl[0]  = '{1'b0, 1'b1, 4'b0001, 1'b1, 8'h30, 1'b0, 3'd0, 1'b0, 1};
        tbl[1]  = '{1'b0, 1'b1, 4'b0100, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 2};
        tbl[2]  = '{1'b0, 1'b1, 4'b0001, 1'b1, 8'h10, 1'b1, 3'd4, 1'b0, 2};
        tbl[3]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 0};
        tbl[4]  = '{1'b0, 1'b1, 4'b0011, 1'b1, 8'h20, 1'b1, 3'd5, 1'b0, 1};
        tbl[5]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 8'h02, 1'b1, 3'd1, 1'b0, 1};
        tbl[6]  = '{1'b0, 1'b1, 4'b0001, 1'b1, 8'h20, 1'b1, 3'd5, 1'b0, 1};
        tbl[7]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 0};
        tbl[8]  = '{1'b0, 1'b1, 4'b0100, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0, 1};
        tbl[9]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 0};
        tbl[10] = '{1'b0, 1'b1, 4'b0001, 1'b1, 8'h30, 1'b0, 3'd0, 1'b0, 1};
        tbl[11] = '{1'b0, 1'b1, 4'b0100, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 2};
        tbl[12] = '{1'b0, 1'b1, 4'b0001, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b1, 0};
        tbl[13] = '{1'b0, 1'b0, 4'b1111, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b1, 0};
        tbl[14] = '{1'b0, 1'b1, 4'b0000, 1'b1, 8'h03, 1'b0, 3'd0, 1'b1, 1};
        tbl[15] = '{1'b1, 1'b1, 4'b0011, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 0};

        r = 1'b0; valid = 1'b0; arm = 1'b0; g_in = 4'd0; g17 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_mask", 32'(mask), 32'hFF);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        check("reset_conflict", 32'(conflict), 32'd0);
`ifdef S27_OBS_STEPCNT_EN
        check("reset_steps", 32'(steps), 32'd0);
`endif

        // An observation presented while reset is held must be ignored.
        valid = 1'b1; g_in = 4'b0011; g17 = 1'b1;
        tick();
        check("inreset_obs_mask", 32'(mask), 32'hFF);
        valid = 1'b0;
        r = 1'b1;

        for (int i = 0; i < 16; i++) begin
            arm = tbl[i].arm; valid = tbl[i].valid; g_in = tbl[i].g; g17 = tbl[i].g17;
            tick();
            check($sformatf("vec%0d_mask", i), 32'(mask), 32'(tbl[i].mask));
            check($sformatf("vec%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
            check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
            check($sformatf("vec%0d_conflict", i), 32'(conflict), 32'(tbl[i].cf));
`ifdef S27_OBS_STEPCNT_EN
            check($sformatf("vec%0d_steps", i), 32'(steps), 32'(tbl[i].steps));
`endif
        end
        arm = 1'b0; valid = 1'b0;

        // Idle edges with wiggling inputs must not move the mask.
        valid = 1'b1; g_in = 4'b0011; g17 = 1'b1;
        tick();
        check("hold_setup_mask", 32'(mask), 32'h20);
        valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            g_in = 4'($urandom_range(0, 15));
            g17 = ~g17;
            tick();
            check($sformatf("hold%0d_mask", i), 32'(mask), 32'h20);
        end

        // Reach mask 8'h10 with a sticky conflict, then reset asynchronously.
        arm = 1'b1; tick(); arm = 1'b0;
        valid = 1'b1;
        g_in = 4'b0001; g17 = 1'b0; tick();
        g_in = 4'b0001; g17 = 1'b1; tick();
        g_in = 4'b0100; g17 = 1'b1; tick();
        g_in = 4'b0001; g17 = 1'b1; tick();
        valid = 1'b0;
        check("prerst_mask", 32'(mask), 32'h10);
        check("prerst_conflict", 32'(conflict), 32'd1);
        #2 r = 1'b0;
        #1;
        check("async_rst_mask", 32'(mask), 32'hFF);
        check("async_rst_locked", 32'(locked), 32'd0);
        check("async_rst_conflict", 32'(conflict), 32'd0);
        check("async_rst_state", 32'(state), 32'd0);
        @(negedge clk);
        r = 1'b1;

`ifdef S27_OBS_STEPCNT_EN
        // Mask settles at 8'h03 under 0000/g17=1 and never locks, so the counter must saturate.
        valid = 1'b1; g_in = 4'b0000; g17 = 1'b1;
        repeat (300) tick();
        valid = 1'b0;
        check("sat_mask", 32'(mask), 32'h03);
        check("sat_steps", 32'(steps), 32'((1 << CNT_W) - 1));
`endif

        // Track a reference s27 from state 0 under random inputs.
        arm = 1'b1; tick(); arm = 1'b0;
        ms = 3'd0;
        seen_lock = 1'b0;
        for (int i = 0; i < 200; i++) begin
            g_in = 4'($urandom_range(0, 15));
            rv = ref_step(ms, g_in);
            g17 = rv[3];
            valid = 1'b1;
            tick();
            ms = rv[2:0];
            check($sformatf("track%0d_true_in_mask", i), 32'(mask[ms]), 32'd1);
            if (locked) seen_lock = 1'b1;
            if (seen_lock) begin
                check($sformatf("track%0d_lk_st_cf", i), 32'({locked, state, conflict}), 32'({1'b1, ms, 1'b0}));
            end
        end
        valid = 1'b0;
        check("track_ever_locked", 32'(seen_lock), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
